// File: rtl/mem_responder.sv
// Memory-side responder: word RAM plus an MMIO window holding TX/RX stream FIFOs.
// Define RESPONDER_CYCLE_COUNTER_EN to build the free-running CYCLES counter at 0xFFF3.
module mem_responder #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);
  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam logic [16:0] RAM_WORDS   = 17'(2 ** ADDR_W);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0] ADDR_TXDATA = 16'hFFF0;
  localparam logic [15:0] ADDR_STATUS = 16'hFFF1;
  localparam logic [15:0] ADDR_RXDATA = 16'hFFF2;
  localparam logic [15:0] ADDR_CYCLES = 16'hFFF3;

  logic [15:0] ram [2 ** ADDR_W];
  logic        isRam;
  logic [ADDR_W-1:0] ramAddr;

  logic [15:0]   txMem [FIFO_DEPTH];
  logic [PW-1:0] txHead, txTail;
  logic [CW-1:0] txCount;
  logic          txFull, txEmpty, txWrite, txPush, txPop, txOvf;

  logic [15:0]   rxMem [FIFO_DEPTH];
  logic [PW-1:0] rxHead, rxTail;
  logic [CW-1:0] rxCount;
  logic          rxFull, rxEmpty, rxRead, rxPush, rxPop, rxUdf;
  logic [15:0]   rxHeadData;

  logic          statusWrite;
  logic [15:0]   status;
  logic [15:0]   cycles;

  assign isRam   = {1'b0, addr} < RAM_WORDS;
  assign ramAddr = addr[ADDR_W-1:0];

  assign txFull    = txCount == DEPTH_C;
  assign txEmpty   = txCount == '0;
  assign txWrite   = we && (addr == ADDR_TXDATA);
  assign txPush    = txWrite && !txFull;
  // Stream handshakes are held off while reset is asserted.
  assign out_valid = !txEmpty && !rst;
  assign out_data  = txMem[txHead];
  assign txPop     = out_valid && out_ready;

  assign rxFull     = rxCount == DEPTH_C;
  assign rxEmpty    = rxCount == '0;
  assign in_ready   = !rxFull && !rst;
  assign rxPush     = in_valid && in_ready;
  assign rxRead     = re && (addr == ADDR_RXDATA);
  assign rxPop      = rxRead && !rxEmpty;
  assign rxHeadData = rxEmpty ? 16'h0000 : rxMem[rxHead];

  assign statusWrite = we && (addr == ADDR_STATUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      txHead  <= '0;
      txTail  <= '0;
      txCount <= '0;
      rxHead  <= '0;
      rxTail  <= '0;
      rxCount <= '0;
      txOvf   <= 1'b0;
      rxUdf   <= 1'b0;
    end else begin
      if (txPush) txTail <= txTail + PW'(1);
      if (txPop)  txHead <= txHead + PW'(1);
      if (txPush && !txPop)      txCount <= txCount + CW'(1);
      else if (!txPush && txPop) txCount <= txCount - CW'(1);

      if (rxPush) rxTail <= rxTail + PW'(1);
      if (rxPop)  rxHead <= rxHead + PW'(1);
      if (rxPush && !rxPop)      rxCount <= rxCount + CW'(1);
      else if (!rxPush && rxPop) rxCount <= rxCount - CW'(1);

      // A new error event outranks a STATUS write in the same cycle.
      txOvf <= (txWrite && txFull) || (txOvf && !statusWrite);
      rxUdf <= (rxRead && rxEmpty) || (rxUdf && !statusWrite);
    end
  end

  always_ff @(posedge clk) begin
    if (we && isRam) ram[ramAddr] <= wdata;
    if (txPush)      txMem[txTail] <= wdata;
    if (rxPush)      rxMem[rxTail] <= in_data;
  end

`ifdef RESPONDER_CYCLE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst) cycles <= '0;
    else     cycles <= cycles + 16'd1;
  end
`else
  assign cycles = 16'h0000;
`endif

  always_comb begin
    status         = '0;
    status[0]      = txFull;
    status[1]      = rxEmpty;
    status[2]      = txOvf;
    status[3]      = rxUdf;
    status[8 +: CW] = rxCount;
  end

  // TXDATA, the reserved MMIO words and the unmapped gap all read as zero.
  always_comb begin
    rdata = 16'h0000;
    if (addr == ADDR_STATUS)      rdata = status;
    else if (addr == ADDR_RXDATA) rdata = rxHeadData;
    else if (addr == ADDR_CYCLES) rdata = cycles;
    else if (isRam)               rdata = ram[ramAddr];
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed test-plan sequences then random traffic,
// checked against a queue-based reference model.
module tb_mem_responder;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wdata, rdata, out_data, in_data;
  logic        we, re, out_valid, out_ready, in_valid, in_ready;

  mem_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] ramM [int];
  logic [15:0] txQ[$];
  logic [15:0] rxQ[$];
  bit          txOvfM, rxUdfM;
  logic [15:0] cycM;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (addr %h, t=%0t)", tag, got, exp, addr, $time);
    end
  endtask

  function automatic logic [15:0] statusM();
    logic [15:0] s;
    s = '0;
    s[0] = (txQ.size() == DEPTH);
    s[1] = (rxQ.size() == 0);
    s[2] = txOvfM;
    s[3] = rxUdfM;
    s[10:8] = 3'(rxQ.size());
    return s;
  endfunction

  // bit16 = expected value is known
  function automatic logic [16:0] expRdata();
    case (addr)
      16'hFFF0: return {1'b1, 16'h0000};
      16'hFFF1: return {1'b1, statusM()};
      16'hFFF2: return {1'b1, (rxQ.size() > 0) ? rxQ[0] : 16'h0000};
`ifdef RESPONDER_CYCLE_COUNTER_EN
      16'hFFF3: return {1'b1, cycM};
`else
      16'hFFF3: return {1'b1, 16'h0000};
`endif
      default: begin
        if (int'(addr) < (1 << ADDR_W)) begin
          if (ramM.exists(int'(addr))) return {1'b1, ramM[int'(addr)]};
          return 17'h0;
        end
        return {1'b1, 16'h0000};
      end
    endcase
  endfunction

  task automatic modelStep();
    bit txFullS, rxFullS, pushRx, popRx, popTx;
    if (we && int'(addr) < (1 << ADDR_W)) ramM[int'(addr)] = wdata;
    if (rst) begin
      txQ.delete();
      rxQ.delete();
      txOvfM = 0;
      rxUdfM = 0;
      cycM   = 16'h0000;
      return;
    end
    txFullS = (txQ.size() == DEPTH);
    rxFullS = (rxQ.size() == DEPTH);
    popTx   = (txQ.size() > 0) && out_ready;
    pushRx  = in_valid && !rxFullS;
    popRx   = re && addr == 16'hFFF2 && rxQ.size() > 0;
    txOvfM  = (we && addr == 16'hFFF0 && txFullS) || (txOvfM && !(we && addr == 16'hFFF1));
    rxUdfM  = (re && addr == 16'hFFF2 && rxQ.size() == 0) || (rxUdfM && !(we && addr == 16'hFFF1));
    if (popTx) void'(txQ.pop_front());
    if (popRx) void'(rxQ.pop_front());
    if (we && addr == 16'hFFF0 && !txFullS) txQ.push_back(wdata);
    if (pushRx) rxQ.push_back(in_data);
    cycM = cycM + 16'd1;
  endtask

  // Inputs are set just after a rising edge; outputs are compared mid-cycle.
  task automatic cycle();
    logic [16:0] e;
    #3;
    e = expRdata();
    if (e[16]) check("rdata", {16'h0, rdata}, {16'h0, e[15:0]});
    check("out_valid", {31'h0, out_valid}, {31'h0, (!rst && txQ.size() > 0)});
    if (!rst && txQ.size() > 0) check("out_data", {16'h0, out_data}, {16'h0, txQ[0]});
    check("in_ready", {31'h0, in_ready}, {31'h0, (!rst && rxQ.size() < DEPTH)});
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; re = 0; addr = 16'hFFF4; wdata = 0;
    out_ready = 0; in_valid = 0; in_data = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    we = 1; re = 0; addr = a; wdata = d;
    cycle();
    we = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    cycle();

    // RAM
    wr(16'h0010, 16'h1234);
    wr(16'h0000, 16'h5555);
    addr = 16'h0010; #1;
    check("ram_read", {16'h0, rdata}, 32'h1234);
    cycle();
    addr = 16'h2000; #1;
    check("gap_read", {16'h0, rdata}, 32'h0);
    wr(16'h2000, 16'hDEAD);
    addr = 16'h0000; #1;
    check("ram_alias", {16'h0, rdata}, 32'h5555);
    cycle();
    wr(16'h0010, 16'h9999);
    addr = 16'h0010; cycle();

    // TX overflow and drain
    out_ready = 0;
    for (int i = 1; i <= 5; i++) wr(16'hFFF0, 16'h00A0 + 16'(i));
    addr = 16'hFFF1; #1;
    check("tx_full", {31'h0, rdata[0]}, 32'h1);
    check("tx_ovf", {31'h0, rdata[2]}, 32'h1);
    cycle();
    out_ready = 1; addr = 16'hFFF4;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("tx_order", {16'h0, out_data}, {16'h0, 16'h00A0 + 16'(i)});
      cycle();
    end
    cycle();
    wr(16'hFFF1, 16'h0000);
    addr = 16'hFFF1; #1;
    check("tx_ovf_clr", {31'h0, rdata[2]}, 32'h0);
    cycle();

    // RX basic
    in_valid = 1; in_data = 16'h0011; cycle();
    in_data = 16'h0022; cycle();
    in_valid = 0; addr = 16'hFFF1; #1;
    check("rx_count", {29'h0, rdata[10:8]}, 32'h2);
    cycle();
    re = 1; addr = 16'hFFF2; #1;
    check("rx_pop1", {16'h0, rdata}, 32'h0011);
    cycle();
    check("rx_pop2", {16'h0, rdata}, 32'h0022);
    cycle();
    check("rx_udf_rd", {16'h0, rdata}, 32'h0);
    cycle();
    re = 0; addr = 16'hFFF1; #1;
    check("rx_udf", {31'h0, rdata[3]}, 32'h1);
    check("rx_empty", {31'h0, rdata[1]}, 32'h1);
    cycle();
    in_valid = 1; in_data = 16'h0033; cycle();
    in_valid = 0; addr = 16'hFFF2; cycle(); cycle();

    // RX full, held beat, then drain
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin in_data = 16'h0100 + 16'(i); cycle(); end
    #1;
    check("rx_full_ready", {31'h0, in_ready}, 32'h0);
    cycle(); cycle();
    re = 1; addr = 16'hFFF2; cycle();
    in_valid = 0;
    for (int i = 0; i < 6; i++) cycle();
    re = 0;

    // TX simultaneous push/pop at count 2
    out_ready = 0;
    wr(16'hFFF0, 16'h0B01);
    wr(16'hFFF0, 16'h0B02);
    out_ready = 1;
    for (int i = 3; i < 7; i++) wr(16'hFFF0, 16'h0B00 + 16'(i));
    for (int i = 0; i < 4; i++) cycle();

    // Reset mid-stream
    out_ready = 0;
    for (int i = 0; i < 3; i++) wr(16'hFFF0, 16'h0C00 + 16'(i));
    rst = 1; cycle();
    rst = 0; addr = 16'hFFF3; #1;
    check("cycles_after_rst", {16'h0, rdata}, 32'h0);
    check("out_valid_after_rst", {31'h0, out_valid}, 32'h0);
    cycle(); cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: addr = 16'hFFF0 + 16'($urandom_range(0, 4));
        5, 8, 9:       addr = 16'($urandom_range(0, 63));
        6:             addr = 16'h2000 + 16'($urandom_range(0, 255));
        default:       addr = 16'hFFEF;
      endcase
      we        = ($urandom_range(0, 2) == 0);
      re        = $urandom_range(0, 1) == 1;
      wdata     = 16'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = 16'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder to the CPU controller's memory interface: the CPU drives address, write enable, write data and read strobe; this block returns read data.
- Contains a word RAM plus a memory-mapped I/O window. The window holds a TX FIFO that drains to an output valid/ready stream, and an RX FIFO filled from an input valid/ready stream.
- Sits between the CPU datapath memory mux and the board-level byte/word stream bridges.

Parameters:
- ADDR_W, 12, RAM address width; RAM occupies 0x0000 to 2^ADDR_W-1 (ADDR_W <= 15).
- FIFO_DEPTH, 4, entries per FIFO; power of 2, >= 2.
- CW, log2(FIFO_DEPTH)+1, FIFO count width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- addr  in  16  word address from CPU memory mux
- we  in  1  write strobe
- re  in  1  read strobe (CPU saveMem/saveOpcode); gates read side effects only
- wdata  in  16  write data
- rdata  out  16  read data, combinational from addr
- out_data  out  16  TX stream data
- out_valid  out  1  TX stream valid
- out_ready  in  1  TX stream ready
- in_data  in  16  RX stream data
- in_valid  in  1  RX stream valid
- in_ready  out  1  RX stream ready

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset: FIFO pointers and counts = 0, sticky bits = 0, cycle counter = 0. During reset out_valid = 0 and in_ready = 0. The first cycle after reset has out_valid = 0 and in_ready = 1. RAM contents are not cleared.
- Address decode (MMIO has priority):
  - 0xFFF0 TXDATA: write pushes to the TX FIFO; read returns 0.
  - 0xFFF1 STATUS: bit0 tx_full, bit1 rx_empty, bit2 tx_ovf (sticky), bit3 rx_udf (sticky), [7:4] reserved 0, [8+CW-1:8] rx_count, rest 0. Any write clears bits 2 and 3.
  - 0xFFF2 RXDATA: read returns the RX head, combinational. re=1 pops it.
  - 0xFFF3 CYCLES: see Optional Feature. Writes are ignored.
  - 0xFFF4 to 0xFFFF, and addresses from 2^ADDR_W up to 0xFFEF: read 0, writes ignored.
  - addr < 2^ADDR_W: RAM.
- RAM: asynchronous read (rdata valid in the same cycle as addr); write on the clk edge when we=1.
  - Same-cycle read of a word being written returns the old value.
  - Read latency 0, write latency 1.
- rdata depends only on addr and state, never on re. Side effects (RX pop, underflow flag) require re=1.
- TX FIFO:
  - Push when we=1, addr=0xFFF0 and not full at the start of the cycle. There is no full-bypass, even when a pop happens in the same cycle.
  - A push while full drops the data and sets tx_ovf.
  - out_valid = !tx_empty; out_data = head.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
- RX FIFO:
  - in_ready = !rx_full (registered state, not combinational from in_valid). Push on in_valid && in_ready.
  - Pop on re=1 && addr=0xFFF2 && !rx_empty.
  - re=1 && addr=0xFFF2 while empty: rdata = 0, no pop, sets rx_udf.
  - Push and pop in the same cycle when not full: count unchanged. When full, in_ready=0, so only the pop occurs.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Counts are CW bits, range 0 to FIFO_DEPTH.
- Sticky bits: if a set and a clear (STATUS write) occur in the same cycle, set wins.
- Reset asserted mid-stream: the pending TX head is discarded and the stream restarts empty. An RX beat presented during reset is not accepted.

Optional Feature:
- Macro RESPONDER_CYCLE_COUNTER_EN.
- Defined: a 16-bit free-running counter increments every non-reset cycle and wraps 0xFFFF->0x0000. It is readable at 0xFFF3.
- Undefined: 0xFFF3 reads 0 and no counter register is built.

Test Plan:
- RAM: write 0x1234 to 0x0010, then read 0x0010 -> rdata=0x1234. Read 0x2000 with ADDR_W=12 -> 0x0000. Write to 0x2000, then read 0x0000 -> unchanged.
- TX: with out_ready=0, write 0xA1, 0xA2, 0xA3, 0xA4, 0xA5 to 0xFFF0 -> STATUS bit0=1, bit2=1. Then with out_ready=1, out_data sequence = A1, A2, A3, A4; 0xA5 is lost. Write STATUS -> bit2=0.
- RX: send 0x0011, 0x0022 on in_* -> STATUS rx_count=2. Read 0xFFF2 with re=1 twice -> 0x0011 then 0x0022, rx_empty=1. A third read -> 0x0000 and rx_udf=1. Reading 0xFFF2 with re=0 -> no pop.
- Full RX: push 4 beats -> in_ready=0. A 5th beat is held until a pop, then accepted; order is preserved.
- Simultaneous TX push and pop with count=2 -> count stays 2, output order correct.
- Assert rst for 1 cycle with TX count=3 and the counter running -> out_valid=0 during reset, counts 0 afterward. With RESPONDER_CYCLE_COUNTER_EN defined, CYCLES reads 0x0000 on the first cycle after reset; undefined, it always reads 0.
